// File: rtl/rr_arbiter_4ch_if.sv
// ============================================================================
// Module   : rr_arbiter_4ch_if
// Purpose  : Request/grant bundle between four requesters and rr_arbiter_4ch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_4ch_if;
    logic [3:0] req;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    // Requester side drives req; arbiter side returns the registered grant.
    modport master (
        output req,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface : rr_arbiter_4ch_if

`default_nettype wire

// File: rtl/rr_arbiter_4ch.sv
// ============================================================================
// Module   : rr_arbiter_4ch
// Purpose  : 4-channel round-robin arbiter with registered binary grant index.
//            Optional grant-hold timeout is compiled in with ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4ch #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    rr_arbiter_4ch_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if ((HOLD_MAX < 2) || (HOLD_MAX > 255) || ((64'd1 << CNT_W) <= 64'(HOLD_MAX))) begin : g_param_check
        $error("rr_arbiter_4ch: illegal HOLD_MAX/CNT_W combination");
    end

    state_t     state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic       valid_q, valid_d;
    logic [1:0] ptr_q,   ptr_d;
    logic       w_end;
    logic       w_expire;
    logic [2:0] w_full_pick;
    logic [2:0] w_mask_pick;

    // Returns {found, index}; search starts at p+1 and wraps; the pointer
    // itself is the last candidate and only considered when incl_self is set.
    function automatic logic [2:0] f_pick(input logic [3:0] r,
                                          input logic [1:0] p,
                                          input logic       incl_self);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            cand = p + 2'(k);
            if (!res[2] && r[cand] && ((k != 4) || incl_self)) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign w_full_pick = f_pick(bus.req, ptr_q, 1'b1);
    assign w_mask_pick = f_pick(bus.req, ptr_q, 1'b0);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign w_expire = bus.req[idx_q] && (cnt_q == c_last_cnt);
`else
    assign w_expire = 1'b0;
`endif

    assign w_end = !bus.req[idx_q] || w_expire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'b00;
            valid_q <= 1'b0;
            ptr_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (w_full_pick[2]) begin
                    state_d = GRANT;
                    idx_d   = w_full_pick[1:0];
                    ptr_d   = w_full_pick[1:0];
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (w_end) begin
                    // Current owner is excluded so a timed-out sole requester
                    // sees one idle bubble before it is re-granted.
                    if (w_mask_pick[2]) begin
                        idx_d   = w_mask_pick[1:0];
                        ptr_d   = w_mask_pick[1:0];
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = w_expire;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule : rr_arbiter_4ch

`default_nettype wire

// File: tb/tb_rr_arbiter_4ch.sv
// ============================================================================
// Module   : tb_rr_arbiter_4ch
// Purpose  : Directed self-checking bench for rr_arbiter_4ch (ARB_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_4ch;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rr_arbiter_4ch_if bus ();

    rr_arbiter_4ch #(
        .HOLD_MAX (8),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic valid, input logic [1:0] idx,
                               input logic tmo);
        check({tag, "_valid"}, {3'b000, bus.gnt_valid}, {3'b000, valid});
        check({tag, "_idx"},   {2'b00, bus.gnt_idx},    {2'b00, idx});
        check({tag, "_tmo"},   {3'b000, bus.timeout},   {3'b000, tmo});
    endtask

    initial begin
        logic [1:0] exp_idx;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.req = 4'b1111;

        // Reset held two cycles with all requests high
        tick();
        tick();
        check_grant("reset", 1'b0, 2'b00, 1'b0);

        rst_n = 1'b1;
        tick();
        check_grant("first_grant", 1'b1, 2'b00, 1'b0);

        // Rotation: each owner drops for one cycle after three grant cycles
        for (int k = 0; k < 4; k++) begin
            exp_idx = 2'(k);
            tick();
            check_grant("rot_hold_a", 1'b1, exp_idx, 1'b0);
            tick();
            check_grant("rot_hold_b", 1'b1, exp_idx, 1'b0);
            bus.req = 4'b1111 & ~(4'b0001 << k);
            tick();
            check_grant("rot_next", 1'b1, exp_idx + 2'd1, 1'b0);
            bus.req = 4'b1111;
        end

        bus.req = 4'b0000;
        tick();
        check_grant("all_release", 1'b0, 2'b00, 1'b0);

        // Single requester on channel 2 for five cycles
        bus.req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant("single_hold", 1'b1, 2'b10, 1'b0);
        end
        bus.req = 4'b0000;
        tick();
        check_grant("single_drop", 1'b0, 2'b10, 1'b0);

        // Other request bits toggling must not disturb the active grant
        bus.req = 4'b0001;
        tick();
        check_grant("nd_grant", 1'b1, 2'b00, 1'b0);
        bus.req = 4'b1011;
        tick();
        check_grant("nd_a", 1'b1, 2'b00, 1'b0);
        bus.req = 4'b0111;
        tick();
        check_grant("nd_b", 1'b1, 2'b00, 1'b0);
        bus.req = 4'b1101;
        tick();
        check_grant("nd_c", 1'b1, 2'b00, 1'b0);

        // Clean restart for the 4'b0011 constant-request case
        rst_n   = 1'b0;
        bus.req = 4'b0011;
        tick();
        rst_n = 1'b1;
        tick();
        check_grant("c3_start", 1'b1, 2'b00, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check_grant("to_ch0", 1'b1, 2'b00, 1'b0);
        end
        tick();
        check_grant("to_switch1", 1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_grant("to_ch1", 1'b1, 2'b01, 1'b0);
        end
        tick();
        check_grant("to_switch0", 1'b1, 2'b00, 1'b1);
        tick();
        check_grant("to_after", 1'b1, 2'b00, 1'b0);

        // Sole requester: bubble cycle carries the timeout pulse
        rst_n   = 1'b0;
        bus.req = 4'b1000;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_grant("sole_hold", 1'b1, 2'b11, 1'b0);
        end
        tick();
        check_grant("sole_bubble", 1'b0, 2'b11, 1'b1);
        tick();
        check_grant("sole_regrant", 1'b1, 2'b11, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check_grant("noto_hold", 1'b1, 2'b00, 1'b0);
        end
`endif

        // Mid-grant reset: grant dropped on that edge and pointer back to 3
        bus.req = 4'b0001;
        tick();
        check_grant("mid_pre", 1'b1, 2'b00, 1'b0);
        bus.req = 4'b0101;
        rst_n   = 1'b0;
        tick();
        check_grant("mid_reset", 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;
        tick();
        check_grant("mid_ptr", 1'b1, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter_4ch

`default_nettype wire
